// File: rtl/axi_line_bridge.sv
// axi_line_bridge: icache/dcache line and uncached requests to AXI3.
// One read outstanding, one buffered write, with a read-after-write guard.
module axi_line_bridge #(
  parameter int LINE_WORDS = 16,
  parameter int LINE_BITS  = 32 * LINE_WORDS
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  output logic [3:0]           arid,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [3:0]           rid,
  input  logic [31:0]          rdata,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [3:0]           awid,
  output logic [31:0]          awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [3:0]           wid,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic                 bvalid,
  input  logic [1:0]           bresp,
  output logic                 bready,
  input  logic                 IF_icache_rd_req,
  input  logic [2:0]           IF_icache_rd_type,
  input  logic [31:0]          IF_icache_rd_addr,
  output logic                 IF_icache_rd_rdy,
  output logic                 IF_icache_ret_valid,
  output logic                 IF_icache_ret_last,
  output logic [31:0]          IF_icache_ret_data,
  input  logic                 MEM_dcache_rd_req,
  input  logic [2:0]           MEM_dcache_rd_type,
  input  logic [31:0]          MEM_dcache_rd_addr,
  output logic                 MEM_dcache_rd_rdy,
  output logic                 MEM_dcache_ret_valid,
  output logic                 MEM_dcache_ret_last,
  output logic [31:0]          MEM_dcache_ret_data,
  input  logic                 MEM_dcache_wr_req,
  input  logic [2:0]           MEM_dcache_wr_type,
  input  logic [31:0]          MEM_dcache_wr_addr,
  input  logic [3:0]           MEM_dcache_wr_wstrb,
  input  logic [LINE_BITS-1:0] MEM_dcache_wr_data,
  output logic                 MEM_dcache_wr_rdy
);

  localparam int OFF_W = $clog2(4 * LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [2:0] T_LINE = 3'b100;
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

  rstate_t r_rstate, w_rnext;
  wstate_t r_wstate, w_wnext;

  logic                 r_rowner;
  logic [31:0]          r_raddr;
  logic [2:0]           r_rtype;
  logic [31:0]          r_waddr;
  logic [2:0]           r_wtype;
  logic [3:0]           r_wstrb;
  logic [LINE_BITS-1:0] r_wbuf;
  logic [IDX_W-1:0]     r_wcnt;

  logic                 w_raw_block;
  logic                 w_d_rdy;
  logic                 w_i_rdy;
  logic                 w_d_acc;
  logic                 w_i_acc;
  logic                 w_wr_acc;
  logic                 w_r_line;
  logic                 w_w_line;
  logic [7:0]           w_awlen;
  logic                 w_cnt_last;
  logic [LINE_WORDS-1:0][31:0] w_words;
  logic                 w_unused;

  assign w_unused = ^{rid, bresp};

  assign w_wr_acc = MEM_dcache_wr_req & (r_wstate == W_IDLE);

  // Dcache reads that hit the in-flight or just-accepted write line wait.
  assign w_raw_block =
    ((MEM_dcache_rd_addr[31:OFF_W] == r_waddr[31:OFF_W]) &
     (r_wstate != W_IDLE)) |
    ((MEM_dcache_rd_addr[31:OFF_W] == MEM_dcache_wr_addr[31:OFF_W]) &
     w_wr_acc);

  assign w_d_rdy = (r_rstate == R_IDLE) & ~w_raw_block;
  assign w_i_rdy = (r_rstate == R_IDLE) & ~MEM_dcache_rd_req;
  assign w_d_acc = MEM_dcache_rd_req & w_d_rdy;
  assign w_i_acc = IF_icache_rd_req & w_i_rdy;

  assign w_r_line   = (r_rtype == T_LINE);
  assign w_w_line   = (r_wtype == T_LINE);
  assign w_awlen    = w_w_line ? LINE_LEN : 8'd0;
  assign w_cnt_last = ({{(8 - IDX_W){1'b0}}, r_wcnt} == w_awlen);
  assign w_words    = r_wbuf[32*LINE_WORDS-1:0];

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rnext;
  end

  // Read FSM next state.
  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (w_d_acc | w_i_acc) w_rnext = R_AR;
      R_AR:   if (arready) w_rnext = R_DATA;
      R_DATA: if (rvalid & rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read FSM outputs: AR channel, rready and return routing.
  always_comb begin
    arvalid              = (r_rstate == R_AR);
    arid                 = {3'b000, r_rowner};
    araddr               = r_raddr;
    arlen                = w_r_line ? LINE_LEN : 8'd0;
    arsize               = w_r_line ? 3'b010 : {1'b0, r_rtype[1:0]};
    arburst              = 2'b01;
    rready               = (r_rstate == R_DATA);
    MEM_dcache_rd_rdy    = w_d_rdy;
    IF_icache_rd_rdy     = w_i_rdy;
    MEM_dcache_ret_valid = rready & rvalid & r_rowner;
    MEM_dcache_ret_last  = rready & rvalid & r_rowner & rlast;
    MEM_dcache_ret_data  = rdata;
    IF_icache_ret_valid  = rready & rvalid & ~r_rowner;
    IF_icache_ret_last   = rready & rvalid & ~r_rowner & rlast;
    IF_icache_ret_data   = rdata;
  end

  // Latch the granted read request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rowner <= 1'b0;
      r_raddr  <= 32'd0;
      r_rtype  <= 3'd0;
    end else if (w_d_acc) begin
      r_rowner <= 1'b1;
      r_raddr  <= MEM_dcache_rd_addr;
      r_rtype  <= MEM_dcache_rd_type;
    end else if (w_i_acc) begin
      r_rowner <= 1'b0;
      r_raddr  <= IF_icache_rd_addr;
      r_rtype  <= IF_icache_rd_type;
    end
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wnext;
  end

  // Write FSM next state.
  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (MEM_dcache_wr_req) w_wnext = W_AW;
      W_AW:   if (awready) w_wnext = W_DATA;
      W_DATA: if (wready & w_cnt_last) w_wnext = W_B;
      W_B:    if (bvalid) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  // Write FSM outputs: AW, W and B channels.
  always_comb begin
    awvalid           = (r_wstate == W_AW);
    awid              = 4'd1;
    awaddr            = r_waddr;
    awlen             = w_awlen;
    awsize            = w_w_line ? 3'b010 : {1'b0, r_wtype[1:0]};
    awburst           = 2'b01;
    wvalid            = (r_wstate == W_DATA);
    wid               = 4'd1;
    wdata             = w_words[r_wcnt];
    wstrb             = w_w_line ? 4'hF : r_wstrb;
    wlast             = wvalid & w_cnt_last;
    bready            = (r_wstate == W_B);
    MEM_dcache_wr_rdy = (r_wstate == W_IDLE);
  end

  // Write buffer capture on acceptance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_waddr <= 32'd0;
      r_wtype <= 3'd0;
      r_wstrb <= 4'd0;
      r_wbuf  <= '0;
    end else if (w_wr_acc) begin
      r_waddr <= MEM_dcache_wr_addr;
      r_wtype <= MEM_dcache_wr_type;
      r_wstrb <= MEM_dcache_wr_wstrb;
      r_wbuf  <= MEM_dcache_wr_data;
    end
  end

  // Beat counter: cleared at AW handshake, stepped per W handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wcnt <= '0;
    end else if (awvalid & awready) begin
      r_wcnt <= '0;
    end else if (wvalid & wready) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_line_bridge.sv
// tb_axi_line_bridge: directed checks of arbitration, bursts,
// read-after-write blocking, uncached accesses and mid-burst reset.
module tb_axi_line_bridge;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic [3:0]   arid, awid, wid, rid;
  logic [31:0]  araddr, awaddr, wdata, rdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [3:0]   wstrb;
  logic         bvalid, bready;
  logic         IF_icache_rd_req, IF_icache_rd_rdy;
  logic [2:0]   IF_icache_rd_type;
  logic [31:0]  IF_icache_rd_addr, IF_icache_ret_data;
  logic         IF_icache_ret_valid, IF_icache_ret_last;
  logic         MEM_dcache_rd_req, MEM_dcache_rd_rdy;
  logic [2:0]   MEM_dcache_rd_type;
  logic [31:0]  MEM_dcache_rd_addr, MEM_dcache_ret_data;
  logic         MEM_dcache_ret_valid, MEM_dcache_ret_last;
  logic         MEM_dcache_wr_req, MEM_dcache_wr_rdy;
  logic [2:0]   MEM_dcache_wr_type;
  logic [31:0]  MEM_dcache_wr_addr;
  logic [3:0]   MEM_dcache_wr_wstrb;
  logic [511:0] MEM_dcache_wr_data;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_line_bridge #(.LINE_WORDS(16), .LINE_BITS(512)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .IF_icache_rd_req(IF_icache_rd_req),
    .IF_icache_rd_type(IF_icache_rd_type),
    .IF_icache_rd_addr(IF_icache_rd_addr),
    .IF_icache_rd_rdy(IF_icache_rd_rdy),
    .IF_icache_ret_valid(IF_icache_ret_valid),
    .IF_icache_ret_last(IF_icache_ret_last),
    .IF_icache_ret_data(IF_icache_ret_data),
    .MEM_dcache_rd_req(MEM_dcache_rd_req),
    .MEM_dcache_rd_type(MEM_dcache_rd_type),
    .MEM_dcache_rd_addr(MEM_dcache_rd_addr),
    .MEM_dcache_rd_rdy(MEM_dcache_rd_rdy),
    .MEM_dcache_ret_valid(MEM_dcache_ret_valid),
    .MEM_dcache_ret_last(MEM_dcache_ret_last),
    .MEM_dcache_ret_data(MEM_dcache_ret_data),
    .MEM_dcache_wr_req(MEM_dcache_wr_req),
    .MEM_dcache_wr_type(MEM_dcache_wr_type),
    .MEM_dcache_wr_addr(MEM_dcache_wr_addr),
    .MEM_dcache_wr_wstrb(MEM_dcache_wr_wstrb),
    .MEM_dcache_wr_data(MEM_dcache_wr_data),
    .MEM_dcache_wr_rdy(MEM_dcache_wr_rdy)
  );

  task automatic nxt;
    @(posedge aclk);
    #1;
  endtask

  task automatic smp;
    @(negedge aclk);
  endtask

  task automatic test_reset;
    arready = 0; rid = 4'd3; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    IF_icache_rd_req = 0; IF_icache_rd_type = 0; IF_icache_rd_addr = 0;
    MEM_dcache_rd_req = 0; MEM_dcache_rd_type = 0; MEM_dcache_rd_addr = 0;
    MEM_dcache_wr_req = 0; MEM_dcache_wr_type = 0; MEM_dcache_wr_addr = 0;
    MEM_dcache_wr_wstrb = 0; MEM_dcache_wr_data = '0;
    #2 aresetn = 0;
    smp();
    checks++; if ({arvalid, awvalid, wvalid, rready, bready, wlast} !== 6'b0) begin errors++; $display("FAIL rst_valids got %b exp 000000", {arvalid, awvalid, wvalid, rready, bready, wlast}); end
    checks++; if ({IF_icache_ret_valid, MEM_dcache_ret_valid} !== 2'b00) begin errors++; $display("FAIL rst_ret_valid got %b exp 00", {IF_icache_ret_valid, MEM_dcache_ret_valid}); end
    checks++; if ({MEM_dcache_wr_rdy, MEM_dcache_rd_rdy, IF_icache_rd_rdy} !== 3'b111) begin errors++; $display("FAIL rst_rdy got %b exp 111", {MEM_dcache_wr_rdy, MEM_dcache_rd_rdy, IF_icache_rd_rdy}); end
    nxt();
    aresetn = 1;
  endtask

  task automatic test_priority;
    IF_icache_rd_req = 1; IF_icache_rd_type = 3'b100; IF_icache_rd_addr = 32'h0000_0100;
    MEM_dcache_rd_req = 1; MEM_dcache_rd_type = 3'b100; MEM_dcache_rd_addr = 32'h0000_8000;
    smp();
    checks++; if ({MEM_dcache_rd_rdy, IF_icache_rd_rdy} !== 2'b10) begin errors++; $display("FAIL prio_rdy got %b exp 10", {MEM_dcache_rd_rdy, IF_icache_rd_rdy}); end
    nxt();
    MEM_dcache_rd_req = 0;
    smp();
    checks++; if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, 4'd1, 32'h8000, 8'd15, 3'd2, 2'd1}) begin errors++; $display("FAIL prio_ar_d got %h exp %h", {arvalid, arid, araddr, arlen, arsize, arburst}, {1'b1, 4'd1, 32'h8000, 8'd15, 3'd2, 2'd1}); end
    checks++; if (IF_icache_rd_rdy !== 1'b0) begin errors++; $display("FAIL prio_i_busy got %b exp 0", IF_icache_rd_rdy); end
    arready = 1; nxt(); arready = 0;
    for (int i = 0; i < 16; i++) begin
      rvalid = 1; rlast = (i == 15); rdata = 32'(32'hD000_0000 + i);
      smp();
      checks++; if ({rready, MEM_dcache_ret_valid, MEM_dcache_ret_last, IF_icache_ret_valid, MEM_dcache_ret_data} !== {1'b1, 1'b1, (i == 15), 1'b0, 32'(32'hD000_0000 + i)}) begin errors++; $display("FAIL prio_dbeat%0d got %h exp %h", i, {rready, MEM_dcache_ret_valid, MEM_dcache_ret_last, IF_icache_ret_valid, MEM_dcache_ret_data}, {1'b1, 1'b1, (i == 15), 1'b0, 32'(32'hD000_0000 + i)}); end
      nxt();
    end
    rvalid = 0; rlast = 0;
    smp();
    checks++; if ({rready, IF_icache_rd_rdy} !== 2'b01) begin errors++; $display("FAIL prio_i_grant got %b exp 01", {rready, IF_icache_rd_rdy}); end
    nxt();
    IF_icache_rd_req = 0;
    smp();
    checks++; if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd0, 32'h100, 8'd15}) begin errors++; $display("FAIL prio_ar_i got %h exp %h", {arvalid, arid, araddr, arlen}, {1'b1, 4'd0, 32'h100, 8'd15}); end
    arready = 1; nxt(); arready = 0;
    for (int i = 0; i < 16; i++) begin
      rvalid = 1; rlast = (i == 15); rdata = 32'(32'hC000_0000 + i);
      smp();
      checks++; if ({IF_icache_ret_valid, IF_icache_ret_last, MEM_dcache_ret_valid, IF_icache_ret_data} !== {1'b1, (i == 15), 1'b0, 32'(32'hC000_0000 + i)}) begin errors++; $display("FAIL prio_ibeat%0d got %h exp %h", i, {IF_icache_ret_valid, IF_icache_ret_last, MEM_dcache_ret_valid, IF_icache_ret_data}, {1'b1, (i == 15), 1'b0, 32'(32'hC000_0000 + i)}); end
      nxt();
    end
    rvalid = 0; rlast = 1;
    smp();
    checks++; if ({rready, IF_icache_ret_valid, IF_icache_ret_last} !== 3'b000) begin errors++; $display("FAIL prio_idle_ret got %b exp 000", {rready, IF_icache_ret_valid, IF_icache_ret_last}); end
    nxt();
    rlast = 0;
  endtask

  task automatic test_write_line;
    logic [511:0] line;
    int b;
    int cyc;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'(32'hA000_0000 + i);
    MEM_dcache_wr_req = 1; MEM_dcache_wr_type = 3'b100;
    MEM_dcache_wr_addr = 32'h0000_1000; MEM_dcache_wr_wstrb = 4'h0;
    MEM_dcache_wr_data = line;
    smp();
    checks++; if (MEM_dcache_wr_rdy !== 1'b1) begin errors++; $display("FAIL wl_rdy got %b exp 1", MEM_dcache_wr_rdy); end
    nxt();
    MEM_dcache_wr_req = 0; MEM_dcache_wr_data = '0;
    smp();
    checks++; if ({awvalid, awid, awaddr, awlen, awsize, awburst, MEM_dcache_wr_rdy} !== {1'b1, 4'd1, 32'h1000, 8'd15, 3'd2, 2'd1, 1'b0}) begin errors++; $display("FAIL wl_aw got %h exp %h", {awvalid, awid, awaddr, awlen, awsize, awburst, MEM_dcache_wr_rdy}, {1'b1, 4'd1, 32'h1000, 8'd15, 3'd2, 2'd1, 1'b0}); end
    awready = 1; nxt(); awready = 0;
    b = 0; cyc = 0;
    while (b < 16 && cyc < 64) begin
      wready = cyc[0];
      smp();
      checks++; if ({wvalid, wid, wstrb, wlast, wdata} !== {1'b1, 4'd1, 4'hF, (b == 15), 32'(32'hA000_0000 + b)}) begin errors++; $display("FAIL wl_beat%0d got %h exp %h", b, {wvalid, wid, wstrb, wlast, wdata}, {1'b1, 4'd1, 4'hF, (b == 15), 32'(32'hA000_0000 + b)}); end
      @(posedge aclk);
      if (wready) b++;
      #1;
      cyc++;
    end
    wready = 0;
    checks++; if (b != 16) begin errors++; $display("FAIL wl_beats got %0d exp 16", b); end
    bvalid = 1; bresp = 2'b10;
    smp();
    checks++; if ({bready, wvalid, MEM_dcache_wr_rdy} !== 3'b100) begin errors++; $display("FAIL wl_b got %b exp 100", {bready, wvalid, MEM_dcache_wr_rdy}); end
    nxt();
    bvalid = 0; bresp = 0;
    smp();
    checks++; if ({bready, MEM_dcache_wr_rdy} !== 2'b01) begin errors++; $display("FAIL wl_idle got %b exp 01", {bready, MEM_dcache_wr_rdy}); end
    nxt();
  endtask

  task automatic test_raw;
    logic [511:0] line;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'(32'hB000_0000 + i);
    MEM_dcache_wr_req = 1; MEM_dcache_wr_type = 3'b100;
    MEM_dcache_wr_addr = 32'h0000_2040; MEM_dcache_wr_data = line;
    MEM_dcache_rd_req = 1; MEM_dcache_rd_type = 3'b010;
    MEM_dcache_rd_addr = 32'h0000_2044;
    #1;
    checks++; if ({MEM_dcache_rd_rdy, MEM_dcache_wr_rdy} !== 2'b01) begin errors++; $display("FAIL raw_same_cycle got %b exp 01", {MEM_dcache_rd_rdy, MEM_dcache_wr_rdy}); end
    MEM_dcache_rd_addr = 32'h0000_3000;
    #1;
    checks++; if (MEM_dcache_rd_rdy !== 1'b1) begin errors++; $display("FAIL raw_other_line got %b exp 1", MEM_dcache_rd_rdy); end
    nxt();
    MEM_dcache_wr_req = 0; MEM_dcache_rd_req = 0;
    smp();
    checks++; if ({arvalid, arid, araddr, arlen, arsize, awvalid, awaddr} !== {1'b1, 4'd1, 32'h3000, 8'd0, 3'd2, 1'b1, 32'h2040}) begin errors++; $display("FAIL raw_concurrent got %h exp %h", {arvalid, arid, araddr, arlen, arsize, awvalid, awaddr}, {1'b1, 4'd1, 32'h3000, 8'd0, 3'd2, 1'b1, 32'h2040}); end
    arready = 1; nxt(); arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'h1234_5678;
    smp();
    checks++; if ({MEM_dcache_ret_valid, MEM_dcache_ret_last, MEM_dcache_ret_data} !== {2'b11, 32'h1234_5678}) begin errors++; $display("FAIL raw_rd_beat got %h exp %h", {MEM_dcache_ret_valid, MEM_dcache_ret_last, MEM_dcache_ret_data}, {2'b11, 32'h1234_5678}); end
    nxt();
    rvalid = 0; rlast = 0;
    MEM_dcache_rd_req = 1; MEM_dcache_rd_addr = 32'h0000_2044;
    for (int k = 0; k < 18; k++) begin
      awready = (k == 0); wready = 1; bvalid = (k == 17);
      smp();
      checks++; if (MEM_dcache_rd_rdy !== 1'b0) begin errors++; $display("FAIL raw_block%0d got %b exp 0", k, MEM_dcache_rd_rdy); end
      if (k == 17) begin
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL raw_bready got %b exp 1", bready); end
      end
      nxt();
    end
    awready = 0; wready = 0; bvalid = 0;
    smp();
    checks++; if ({MEM_dcache_rd_rdy, MEM_dcache_wr_rdy} !== 2'b11) begin errors++; $display("FAIL raw_release got %b exp 11", {MEM_dcache_rd_rdy, MEM_dcache_wr_rdy}); end
    nxt();
    MEM_dcache_rd_req = 0;
    smp();
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h2044}) begin errors++; $display("FAIL raw_ar got %h exp %h", {arvalid, araddr}, {1'b1, 32'h2044}); end
    arready = 1; nxt(); arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'hB000_0001;
    nxt();
    rvalid = 0; rlast = 0;
  endtask

  task automatic test_uncached_read;
    IF_icache_rd_req = 1; IF_icache_rd_type = 3'b001;
    IF_icache_rd_addr = 32'hBFD0_0002;
    smp();
    checks++; if (IF_icache_rd_rdy !== 1'b1) begin errors++; $display("FAIL ur_rdy got %b exp 1", IF_icache_rd_rdy); end
    nxt();
    IF_icache_rd_req = 0;
    smp();
    checks++; if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, 4'd0, 32'hBFD0_0002, 8'd0, 3'd1}) begin errors++; $display("FAIL ur_ar got %h exp %h", {arvalid, arid, araddr, arlen, arsize}, {1'b1, 4'd0, 32'hBFD0_0002, 8'd0, 3'd1}); end
    arready = 1; nxt(); arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'h0000_BEEF;
    smp();
    checks++; if ({IF_icache_ret_valid, IF_icache_ret_last, IF_icache_ret_data} !== {2'b11, 32'h0000_BEEF}) begin errors++; $display("FAIL ur_beat got %h exp %h", {IF_icache_ret_valid, IF_icache_ret_last, IF_icache_ret_data}, {2'b11, 32'h0000_BEEF}); end
    nxt();
    rvalid = 0; rlast = 0;
    smp();
    checks++; if ({rready, IF_icache_ret_valid} !== 2'b00) begin errors++; $display("FAIL ur_done got %b exp 00", {rready, IF_icache_ret_valid}); end
    nxt();
  endtask

  task automatic test_uncached_write;
    logic [511:0] line;
    line = '0;
    line[31:0] = 32'h00AB_0000;
    line[63:32] = 32'hDEAD_BEEF;
    MEM_dcache_wr_req = 1; MEM_dcache_wr_type = 3'b000;
    MEM_dcache_wr_addr = 32'h0000_0042; MEM_dcache_wr_wstrb = 4'b0100;
    MEM_dcache_wr_data = line;
    smp();
    checks++; if (MEM_dcache_wr_rdy !== 1'b1) begin errors++; $display("FAIL uw_rdy got %b exp 1", MEM_dcache_wr_rdy); end
    nxt();
    MEM_dcache_wr_req = 0; MEM_dcache_wr_wstrb = 4'hF;
    smp();
    checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h42, 8'd0, 3'd0}) begin errors++; $display("FAIL uw_aw got %h exp %h", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'h42, 8'd0, 3'd0}); end
    awready = 1; nxt(); awready = 0;
    wready = 1;
    smp();
    checks++; if ({wvalid, wstrb, wlast, wdata} !== {1'b1, 4'b0100, 1'b1, 32'h00AB_0000}) begin errors++; $display("FAIL uw_w got %h exp %h", {wvalid, wstrb, wlast, wdata}, {1'b1, 4'b0100, 1'b1, 32'h00AB_0000}); end
    nxt();
    wready = 0;
    smp();
    checks++; if ({bready, wvalid} !== 2'b10) begin errors++; $display("FAIL uw_b got %b exp 10", {bready, wvalid}); end
    bvalid = 1; nxt(); bvalid = 0;
    smp();
    checks++; if (MEM_dcache_wr_rdy !== 1'b1) begin errors++; $display("FAIL uw_idle got %b exp 1", MEM_dcache_wr_rdy); end
    nxt();
  endtask

  task automatic test_reset_mid;
    IF_icache_rd_req = 1; IF_icache_rd_type = 3'b100;
    IF_icache_rd_addr = 32'h0000_0600;
    nxt();
    IF_icache_rd_req = 0;
    arready = 1; nxt(); arready = 0;
    for (int i = 0; i < 6; i++) begin
      rvalid = 1; rdata = 32'(32'hE000_0000 + i);
      nxt();
    end
    rdata = 32'hE000_0006;
    #1;
    checks++; if ({rready, IF_icache_ret_valid} !== 2'b11) begin errors++; $display("FAIL rm_beat7 got %b exp 11", {rready, IF_icache_ret_valid}); end
    aresetn = 0;
    #1;
    checks++; if ({rready, IF_icache_ret_valid, IF_icache_ret_last, MEM_dcache_ret_valid, arvalid} !== 5'b0) begin errors++; $display("FAIL rm_async got %b exp 00000", {rready, IF_icache_ret_valid, IF_icache_ret_last, MEM_dcache_ret_valid, arvalid}); end
    rvalid = 0;
    nxt();
    aresetn = 1;
    IF_icache_rd_req = 1; IF_icache_rd_type = 3'b010;
    IF_icache_rd_addr = 32'h0000_0700;
    smp();
    checks++; if ({IF_icache_rd_rdy, rready} !== 2'b10) begin errors++; $display("FAIL rm_regrant got %b exp 10", {IF_icache_rd_rdy, rready}); end
    nxt();
    IF_icache_rd_req = 0;
    smp();
    checks++; if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd0, 32'h700, 8'd0}) begin errors++; $display("FAIL rm_ar got %h exp %h", {arvalid, arid, araddr, arlen}, {1'b1, 4'd0, 32'h700, 8'd0}); end
    arready = 1; nxt(); arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'h7777_0000;
    smp();
    checks++; if ({IF_icache_ret_valid, IF_icache_ret_last, IF_icache_ret_data} !== {2'b11, 32'h7777_0000}) begin errors++; $display("FAIL rm_beat got %h exp %h", {IF_icache_ret_valid, IF_icache_ret_last, IF_icache_ret_data}, {2'b11, 32'h7777_0000}); end
    nxt();
    rvalid = 0; rlast = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_write_line();
    test_raw();
    test_uncached_read();
    test_uncached_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
